// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-organised data RAM behind a valid/ready load/store
//               request/response handshake with programmable access latency.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_cnt_init = 2'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic [3:0]        r_wmask;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       r_mem [2**ADDR_W];

    logic              w_accept;
    logic              w_access;
    logic              w_range_err;
    logic              w_mask_ok;
    logic              w_err;
    logic              w_commit;
    logic [ADDR_W-1:0] w_idx;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_access    = (r_state == S_BUSY) && (r_cnt == 2'd0);
    // Any address bit above the word index makes the request out of range.
    assign w_range_err = |(r_addr >> (ADDR_W + 2));
    assign w_err       = w_range_err || (r_we && !w_mask_ok);
    assign w_commit    = w_access && r_we && !w_err;
    assign w_idx       = r_addr[ADDR_W+1:2];

    always_comb begin
        w_mask_ok = 1'b0;
        case (r_wmask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_mask_ok = 1'b1;
            default:                   w_mask_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)        w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 2'd0)    w_next = S_RESP;
            S_RESP:  if (rsp_ready)        w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_wmask <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_wmask <= req_wmask;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_cnt_init;
            end else if ((r_state == S_BUSY) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at LATENCY 1, 3 and 4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [3:0]  req_wmask [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat [3]  = '{1, 3, 4};
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_wmask(req_wmask[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_wmask(req_wmask[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_wmask(req_wmask[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One full transaction: drive, push expectation, wait for the response,
    // optionally hold backpressure, then consume and check return to idle.
    task automatic do_req(input int u, input logic we, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd,
                          input int hold, input bit scramble);
        int   cyc;
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_wmask[u] = m;
        req_addr[u]  = a;
        req_wdata[u] = d;
        e.err   = e_err;
        e.rdata = e_rd;
        sb.push_back(e);
        @(negedge clk);
        req_valid[u] = 1'b0;
        if (scramble) begin
            req_addr[u]  = a + 32'd4;
            req_wdata[u] = ~d;
            req_wmask[u] = 4'b0110;
        end
        cyc = 0;
        while (!rsp_valid[u] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat[u]));
        e = sb.pop_front();
        check("rsp_err", 32'(rsp_err[u]), 32'(e.err));
        check("rsp_rdata", rsp_rdata[u], e.rdata);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid[u]), 32'd1);
            check("bp_req_ready", 32'(req_ready[u]), 32'd0);
            check("bp_rdata", rsp_rdata[u], e.rdata);
            check("bp_err", 32'(rsp_err[u]), 32'(e.err));
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid[u]), 32'd0);
        check("req_ready_back", 32'(req_ready[u]), 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_wmask[u] = 4'd0;
            req_addr[u] = 32'd0; req_wdata[u] = 32'd0; rsp_ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_req_ready", 32'(req_ready[u]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
            check("rst_rdata", rsp_rdata[u], 32'd0);
            check("rst_err", 32'(rsp_err[u]), 32'd0);
        end
        u_l1.r_mem[8]    = 32'h11223344;
        u_l1.r_mem[1023] = 32'h00000000;
        u_l3.r_mem[16]   = 32'h00000000;
        u_l3.r_mem[17]   = 32'h00000000;
        u_l4.r_mem[12]   = 32'h00000000;
        rst = 1'b0;

        // LATENCY=1: full word, lanes, errors, top word
        do_req(0, 1'b1, 4'b1111, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 0, 1'b0);
        do_req(0, 1'b1, 4'b0100, 32'h20,   32'h00AA0000, 1'b0, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h20,   32'h0,        1'b0, 32'h11AA3344, 0, 1'b0);
        do_req(0, 1'b1, 4'b0011, 32'h20,   32'h0000BBCC, 1'b0, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h20,   32'h0,        1'b0, 32'h11AABBCC, 0, 1'b0);
        do_req(0, 1'b1, 4'b0110, 32'h20,   32'hFFFFFFFF, 1'b1, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h20,   32'h0,        1'b0, 32'h11AABBCC, 0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h1000, 32'h0,        1'b1, 32'h0,        0, 1'b0);
        do_req(0, 1'b1, 4'b1111, 32'h1010, 32'h12345678, 1'b1, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 0, 1'b0);
        do_req(0, 1'b1, 4'b1000, 32'hFFC,  32'hAB000000, 1'b0, 32'h0,        0, 1'b0);
        do_req(0, 1'b0, 4'b0000, 32'hFFE,  32'h0,        1'b0, 32'hAB000000, 0, 1'b0);

        // LATENCY=3: backpressure and input isolation
        do_req(1, 1'b1, 4'b1111, 32'h40,   32'hCAFEF00D, 1'b0, 32'h0,        5, 1'b1);
        do_req(1, 1'b0, 4'b0000, 32'h43,   32'h0,        1'b0, 32'hCAFEF00D, 5, 1'b0);
        do_req(1, 1'b0, 4'b0000, 32'h44,   32'h0,        1'b0, 32'h0,        0, 1'b0);

        // LATENCY=4: reset lands before the write commits
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_wmask[2] = 4'b1111;
        req_addr[2] = 32'h30; req_wdata[2] = 32'h55555555;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready[2]), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1'b1;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        do_req(2, 1'b0, 4'b0000, 32'h30,   32'h0,        1'b0, 32'h0,        0, 1'b0);
        do_req(2, 1'b1, 4'b1100, 32'h30,   32'h55550000, 1'b0, 32'h0,        0, 1'b0);
        do_req(2, 1'b0, 4'b0000, 32'h31,   32'h0,        1'b0, 32'h55550000, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
